// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline control blocks.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0     = 5'd0;
  localparam int         MEM_LOAD_W = 3;

endpackage

// File: rtl/hz_detect.sv
// Load-use comparator: the load in E writes a register the instruction in D reads.
import pipe_pkg::*;

module hz_detect (
  input  logic [4:0]            rs1D,
  input  logic [4:0]            rs2D,
  input  logic                  use_rs1D,
  input  logic                  use_rs2D,
  input  logic [4:0]            rdE,
  input  logic [MEM_LOAD_W-1:0] mem_loadE,
  input  logic                  reg_writeE,
  output logic                  hz
);

  logic load_wr_s;
  logic match_s;

  assign load_wr_s = (mem_loadE != {MEM_LOAD_W{1'b0}}) && reg_writeE && (rdE != REG_X0);
  assign match_s   = (use_rs1D && (rs1D == rdE)) || (use_rs2D && (rs2D == rdE));
  assign hz        = load_wr_s && match_s;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, mispredict flush, memory-wait freeze,
// saturating stall/flush counters and a sticky memory-timeout flag.
import pipe_pkg::*;

module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4:0]            rs1D,
  input  logic [4:0]            rs2D,
  input  logic                  use_rs1D,
  input  logic                  use_rs2D,
  input  logic [4:0]            rdE,
  input  logic [MEM_LOAD_W-1:0] mem_loadE,
  input  logic                  reg_writeE,
  input  logic                  fail_predictE,
  input  logic                  mem_reqM,
  input  logic                  mem_readyM,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  bubbleE,
  output logic                  flushD,
  output logic                  freeze,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  mem_err
);

  localparam bit         MULTI_BUBBLE = (LOAD_BUBBLES > 1);
  localparam logic [1:0] BCNT_INIT    = 2'(LOAD_BUBBLES - 1);
  localparam logic [7:0] TMO_LIM      = 8'(MEM_TIMEOUT - 1);

  hz_state_e        state_r, state_n_s;
  hz_state_e        ret_r, ret_n_s;
  logic [1:0]       bcnt_r, bcnt_n_s;
  logic [7:0]       wcnt_r, wcnt_n_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             mem_err_r, mem_err_n_s;

  logic hz_s, mw_s;
  logic stall_s, bubble_s, flush_s, freeze_s;
  logic stall_g_s, bubble_g_s, flush_g_s, freeze_g_s;

  hz_detect u_hz_detect (
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .use_rs1D   (use_rs1D),
    .use_rs2D   (use_rs2D),
    .rdE        (rdE),
    .mem_loadE  (mem_loadE),
    .reg_writeE (reg_writeE),
    .hz         (hz_s)
  );

  assign mw_s = mem_reqM && !mem_readyM;

  // Next-state and Mealy control decode, highest-priority condition first
  always_comb begin
    state_n_s = state_r;
    ret_n_s   = ret_r;
    bcnt_n_s  = bcnt_r;
    wcnt_n_s  = wcnt_r;
    stall_s   = 1'b0;
    bubble_s  = 1'b0;
    flush_s   = 1'b0;
    freeze_s  = 1'b0;
    if (mw_s) begin
      stall_s  = 1'b1;
      freeze_s = 1'b1;
      if (state_r == MEMWAIT) begin
        if (wcnt_r != 8'hFF) begin
          wcnt_n_s = wcnt_r + 8'd1;
        end else begin
          wcnt_n_s = wcnt_r;
        end
      end else begin
        ret_n_s   = state_r;
        wcnt_n_s  = 8'd0;
        state_n_s = MEMWAIT;
      end
    end else if (state_r == MEMWAIT) begin
      // Wait finished: one idle cycle, any pending mispredict is seen next cycle
      state_n_s = ret_r;
    end else if (fail_predictE) begin
      flush_s   = 1'b1;
      state_n_s = RUN;
      bcnt_n_s  = 2'd0;
    end else if ((state_r == RUN) && hz_s) begin
      stall_s  = 1'b1;
      bubble_s = 1'b1;
      if (MULTI_BUBBLE) begin
        bcnt_n_s  = BCNT_INIT;
        state_n_s = LDSTALL;
      end else begin
        state_n_s = RUN;
      end
    end else if (state_r == LDSTALL) begin
      stall_s  = 1'b1;
      bubble_s = 1'b1;
      if (bcnt_r <= 2'd1) begin
        bcnt_n_s  = 2'd0;
        state_n_s = RUN;
      end else begin
        bcnt_n_s  = bcnt_r - 2'd1;
        state_n_s = LDSTALL;
      end
    end else begin
      state_n_s = RUN;
    end
  end

  // Reset masks every combinational control
  always_comb begin
    if (RST) begin
      stall_g_s  = 1'b0;
      bubble_g_s = 1'b0;
      flush_g_s  = 1'b0;
      freeze_g_s = 1'b0;
    end else begin
      stall_g_s  = stall_s;
      bubble_g_s = bubble_s;
      flush_g_s  = flush_s;
      freeze_g_s = freeze_s;
    end
  end

  // Timeout flag is sticky; it trips once the wait count reaches the limit
  always_comb begin
    if (mw_s && (wcnt_n_s >= TMO_LIM)) begin
      mem_err_n_s = 1'b1;
    end else begin
      mem_err_n_s = mem_err_r;
    end
  end

  // FSM, wait/bubble counters and timeout flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= RUN;
      ret_r     <= RUN;
      bcnt_r    <= 2'd0;
      wcnt_r    <= 8'd0;
      mem_err_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      ret_r     <= ret_n_s;
      bcnt_r    <= bcnt_n_s;
      wcnt_r    <= wcnt_n_s;
      mem_err_r <= mem_err_n_s;
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_g_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_g_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stallF    = stall_g_s;
  assign stallD    = stall_g_s;
  assign bubbleE   = bubble_g_s;
  assign flushD    = flush_g_s;
  assign freeze    = freeze_g_s;
  assign state     = state_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
  assign mem_err   = mem_err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance A (1 bubble, timeout 4), instance B (3 bubbles).
module tb_hazard_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_LD = 2'd1, S_MW = 2'd2;
  // Control bundle order: {stallF, stallD, bubbleE, flushD, freeze}
  localparam logic [4:0] C_ID = 5'b00000, C_LU = 5'b11100, C_FL = 5'b00010, C_FZ = 5'b11001;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] rs1D = 5'd0, rs2D = 5'd0, rdE = 5'd0;
  logic       use_rs1D = 1'b0, use_rs2D = 1'b0, reg_writeE = 1'b0;
  logic [2:0] mem_loadE = 3'd0;
  logic       fail_predictE = 1'b0, mem_reqM = 1'b0, mem_readyM = 1'b0;

  logic        a_stallF, a_stallD, a_bubbleE, a_flushD, a_freeze, a_mem_err;
  logic [1:0]  a_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_stallF, b_stallD, b_bubbleE, b_flushD, b_freeze, b_mem_err;
  logic [1:0]  b_state;
  logic [15:0] b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(16)) u_dut_a (
    .CLK(CLK), .RST(RST), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .rdE(rdE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE), .fail_predictE(fail_predictE),
    .mem_reqM(mem_reqM), .mem_readyM(mem_readyM), .stallF(a_stallF), .stallD(a_stallD),
    .bubbleE(a_bubbleE), .flushD(a_flushD), .freeze(a_freeze), .state(a_state),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .mem_err(a_mem_err)
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) u_dut_b (
    .CLK(CLK), .RST(RST), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .rdE(rdE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE), .fail_predictE(fail_predictE),
    .mem_reqM(mem_reqM), .mem_readyM(mem_readyM), .stallF(b_stallF), .stallD(b_stallD),
    .bubbleE(b_bubbleE), .flushD(b_flushD), .freeze(b_freeze), .state(b_state),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .mem_err(b_mem_err)
  );

  wire [4:0] a_ctl = {a_stallF, a_stallD, a_bubbleE, a_flushD, a_freeze};
  wire [4:0] b_ctl = {b_stallF, b_stallD, b_bubbleE, b_flushD, b_freeze};

  typedef struct {
    logic        sel;
    logic        rst;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic [2:0]  ld;
    logic        rw;
    logic        fp;
    logic        req;
    logic        rdy;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        err;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(input logic sel, input logic rst, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic [2:0] ld, input logic rw, input logic fp, input logic req,
                              input logic rdy, input logic [4:0] ctl, input logic [1:0] st,
                              input logic [15:0] sc, input logic [15:0] fc, input logic err);
    vec_t v;
    v.sel = sel; v.rst = rst; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.ld = ld; v.rw = rw; v.fp = fp; v.req = req; v.rdy = rdy; v.ctl = ctl; v.st = st;
    v.sc = sc; v.fc = fc; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic [2:0] ld, input logic rw,
                       input logic fp, input logic req, input logic rdy);
    RST = rst; rs1D = rs1; use_rs1D = u1; rs2D = rs2; use_rs2D = u2; rdE = rd;
    mem_loadE = ld; reg_writeE = rw; fail_predictE = fp; mem_reqM = req; mem_readyM = rdy;
  endtask

  task automatic idle_cycle(input logic rst);
    @(negedge CLK);
    drive(rst, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // sel rst rs1 u1 rs2 u2 rd ld rw fp req rdy | ctl st sc fc err
    vecs[0]  = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd0,16'd0,0);
    vecs[1]  = mk(0,0, 5'd5,1, 5'd0,0, 5'd5,3'b010,1, 0,0,0, C_LU,S_RUN, 16'd0,16'd0,0);
    vecs[2]  = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd1,16'd0,0);
    vecs[3]  = mk(0,0, 5'd0,1, 5'd0,0, 5'd0,3'b010,1, 0,0,0, C_ID,S_RUN, 16'd1,16'd0,0);
    vecs[4]  = mk(0,0, 5'd5,0, 5'd0,0, 5'd5,3'b010,1, 0,0,0, C_ID,S_RUN, 16'd1,16'd0,0);
    vecs[5]  = mk(0,0, 5'd0,0, 5'd7,1, 5'd7,3'b001,1, 0,0,0, C_LU,S_RUN, 16'd1,16'd0,0);
    vecs[6]  = mk(0,0, 5'd0,0, 5'd7,1, 5'd7,3'b000,1, 0,0,0, C_ID,S_RUN, 16'd2,16'd0,0);
    vecs[7]  = mk(0,0, 5'd0,0, 5'd7,1, 5'd7,3'b100,0, 0,0,0, C_ID,S_RUN, 16'd2,16'd0,0);
    vecs[8]  = mk(0,0, 5'd5,1, 5'd0,0, 5'd5,3'b010,1, 1,0,0, C_FL,S_RUN, 16'd2,16'd0,0);
    vecs[9]  = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd2,16'd1,0);
    vecs[10] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,1,0, C_FZ,S_RUN, 16'd2,16'd1,0);
    vecs[11] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,1,0, C_FZ,S_MW,  16'd3,16'd1,0);
    vecs[12] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,1,0, C_FZ,S_MW,  16'd4,16'd1,0);
    vecs[13] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,1,1, C_ID,S_MW,  16'd5,16'd1,0);
    vecs[14] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd5,16'd1,0);
    vecs[15] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 1,1,0, C_FZ,S_RUN, 16'd5,16'd1,0);
    vecs[16] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 1,1,1, C_ID,S_MW,  16'd6,16'd1,0);
    vecs[17] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 1,0,0, C_FL,S_RUN, 16'd6,16'd1,0);
    vecs[18] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd6,16'd2,0);
    vecs[19] = mk(0,1, 5'd5,1, 5'd0,0, 5'd5,3'b010,1, 0,0,0, C_ID,S_RUN, 16'd6,16'd2,0);
    vecs[20] = mk(0,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd0,16'd0,0);
    // Instance B: three bubbles with a two-cycle freeze in the middle
    vecs[21] = mk(1,0, 5'd5,1, 5'd0,0, 5'd5,3'b010,1, 0,0,0, C_LU,S_RUN, 16'd0,16'd0,0);
    vecs[22] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,1,0, C_FZ,S_LD,  16'd1,16'd0,0);
    vecs[23] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,1,0, C_FZ,S_MW,  16'd2,16'd0,0);
    vecs[24] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,1,1, C_ID,S_MW,  16'd3,16'd0,0);
    vecs[25] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_LU,S_LD,  16'd3,16'd0,0);
    vecs[26] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_LU,S_LD,  16'd4,16'd0,0);
    vecs[27] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd5,16'd0,0);
    vecs[28] = mk(1,0, 5'd9,1, 5'd0,0, 5'd9,3'b011,1, 0,0,0, C_LU,S_RUN, 16'd5,16'd0,0);
    vecs[29] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 1,0,0, C_FL,S_LD,  16'd6,16'd0,0);
    vecs[30] = mk(1,0, 5'd0,0, 5'd0,0, 5'd0,3'b000,0, 0,0,0, C_ID,S_RUN, 16'd6,16'd1,0);

    // Reset and idle state
    idle_cycle(1'b1);
    check("rst_ctl_forced", {27'd0, a_ctl}, {27'd0, C_ID});
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    check("rst_state", {30'd0, a_state}, {30'd0, S_RUN});
    check("rst_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
    check("rst_flush_cnt", {16'd0, a_flush_cnt}, 32'd0);
    check("rst_mem_err", {31'd0, a_mem_err}, 32'd0);

    for (int i = 0; i < 31; i++) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, vecs[i].rd,
            vecs[i].ld, vecs[i].rw, vecs[i].fp, vecs[i].req, vecs[i].rdy);
      #1;
      if (vecs[i].sel) begin
        check($sformatf("v%0d_ctl", i), {27'd0, b_ctl}, {27'd0, vecs[i].ctl});
        check($sformatf("v%0d_state", i), {30'd0, b_state}, {30'd0, vecs[i].st});
        check($sformatf("v%0d_stall_cnt", i), {16'd0, b_stall_cnt}, {16'd0, vecs[i].sc});
        check($sformatf("v%0d_flush_cnt", i), {16'd0, b_flush_cnt}, {16'd0, vecs[i].fc});
        check($sformatf("v%0d_mem_err", i), {31'd0, b_mem_err}, {31'd0, vecs[i].err});
      end else begin
        check($sformatf("v%0d_ctl", i), {27'd0, a_ctl}, {27'd0, vecs[i].ctl});
        check($sformatf("v%0d_state", i), {30'd0, a_state}, {30'd0, vecs[i].st});
        check($sformatf("v%0d_stall_cnt", i), {16'd0, a_stall_cnt}, {16'd0, vecs[i].sc});
        check($sformatf("v%0d_flush_cnt", i), {16'd0, a_flush_cnt}, {16'd0, vecs[i].fc});
        check($sformatf("v%0d_mem_err", i), {31'd0, a_mem_err}, {31'd0, vecs[i].err});
      end
    end

    // Timeout on A: ready never comes; flag visible after the 4th wait cycle
    idle_cycle(1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check($sformatf("tmo_c%0d_ctl", k), {27'd0, a_ctl}, {27'd0, C_FZ});
      check($sformatf("tmo_c%0d_state", k), {30'd0, a_state}, {30'd0, (k >= 2) ? S_MW : S_RUN});
      check($sformatf("tmo_c%0d_mem_err", k), {31'd0, a_mem_err}, {31'd0, (k >= 5) ? 1'b1 : 1'b0});
    end
    idle_cycle(1'b0);
    check("tmo_release_state", {30'd0, a_state}, {30'd0, S_MW});
    check("tmo_release_err", {31'd0, a_mem_err}, 32'd1);
    idle_cycle(1'b0);
    check("tmo_sticky_err", {31'd0, a_mem_err}, 32'd1);
    check("tmo_state_run", {30'd0, a_state}, {30'd0, S_RUN});
    check("tmo_stall_cnt", {16'd0, a_stall_cnt}, 32'd8);

    // Reset while in MEMWAIT with the wait still pending
    @(negedge CLK);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("rstmw_ctl_forced", {27'd0, a_ctl}, {27'd0, C_ID});
    idle_cycle(1'b0);
    check("rstmw_state", {30'd0, a_state}, {30'd0, S_RUN});
    check("rstmw_mem_err", {31'd0, a_mem_err}, 32'd0);
    check("rstmw_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
    check("rstmw_flush_cnt", {16'd0, a_flush_cnt}, 32'd0);

    // Reset in the middle of B's load bubbles
    @(negedge CLK);
    drive(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("rstld_hz_ctl", {27'd0, b_ctl}, {27'd0, C_LU});
    idle_cycle(1'b1);
    check("rstld_ctl_forced", {27'd0, b_ctl}, {27'd0, C_ID});
    idle_cycle(1'b0);
    check("rstld_state", {30'd0, b_state}, {30'd0, S_RUN});
    check("rstld_ctl_idle", {27'd0, b_ctl}, {27'd0, C_ID});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
